// File: rtl/tdm_demux2.sv
// tdm_demux2: receive-side 1:2 TDM demultiplexer.
// Samples a serial line carrying two interleaved WIDTH-bit words (even frame
// bits = channel 0, odd frame bits = channel 1, each word LSB first) and
// delivers both words in parallel with a one-cycle valid pulse. A sof seen
// mid-frame aborts the partial frame with a one-cycle frame_err pulse and
// restarts reception from that bit.
module tdm_demux2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sof,
    input  logic             din,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = (2 * WIDTH > 1) ? $clog2(2 * WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             recv_s;
    logic             take_s;
    logic             final_s;
    logic [CW-1:0]    pos_s;
    logic [WIDTH-1:0] mask_s;

    // Strobe qualification shared by the FSM, datapath and output logic.
    always_comb begin
        recv_s  = (state_q == RECV);
        take_s  = en & (sof | recv_s);
        final_s = en & recv_s & ~sof & (cnt_q == LAST);
        // A sof always lands in frame position 0, whatever the counter says.
        if (sof) begin
            pos_s = {CW{1'b0}};
        end else begin
            pos_s = cnt_q;
        end
        mask_s = WIDTH'(1'b1) << (pos_s >> 1);
    end

    // Next-state logic: sof enters/restarts RECV, the final bit returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en && sof) begin
                    state_d = RECV;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (final_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: steer the sampled bit into its channel word, advance the
    // counter, and publish both words on the edge that captures the final bit.
    always_comb begin
        cnt_d = cnt_q;
        sh0_d = sh0_q;
        sh1_d = sh1_q;
        q0_d  = q0_q;
        q1_d  = q1_q;
        if (take_s) begin
            if (pos_s[0] == 1'b0) begin
                sh0_d = (sh0_q & ~mask_s) | ({WIDTH{din}} & mask_s);
            end else begin
                sh1_d = (sh1_q & ~mask_s) | ({WIDTH{din}} & mask_s);
            end
            if (sof) begin
                cnt_d = CW'(1);
            end else if (cnt_q == LAST) begin
                cnt_d = {CW{1'b0}};
                q0_d  = sh0_d;
                q1_d  = sh1_d;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output logic: next values of the registered status outputs.
    always_comb begin
        valid_d = final_s;
        err_d   = en & recv_s & sof;
        busy_d  = (state_d == RECV);
    end

    // State, counter and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            sh0_q   <= {WIDTH{1'b0}};
            sh1_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0_q    <= {WIDTH{1'b0}};
            q1_q    <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign q0        = q0_q;
    assign q1        = q1_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed testbench for tdm_demux2 with WIDTH=4.
module tb_tdm_demux2;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sof;
    logic       din;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       valid;
    logic       busy;
    logic       frame_err;

    int checks;
    int failures;

    tdm_demux2 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sof       (sof),
        .din       (din),
        .q0        (q0),
        .q1        (q1),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic e, input logic s, input logic d);
        en  = e;
        sof = s;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic v, input logic b, input logic fe);
        check({tag, ".valid"}, {15'd0, valid}, {15'd0, v});
        check({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        check({tag, ".err"}, {15'd0, frame_err}, {15'd0, fe});
    endtask

    task automatic words(input string tag, input logic [3:0] e0, input logic [3:0] e1);
        check({tag, ".q0"}, {12'd0, q0}, {12'd0, e0});
        check({tag, ".q1"}, {12'd0, q1}, {12'd0, e1});
    endtask

    logic [7:0] fa;   // 0,1,1,1,0,0,1,0 in bit order 0..7 -> q0=A q1=3
    logic [7:0] fb;   // 1,0,1,0,1,0,1,0 -> q0=F q1=0
    logic [7:0] fc;   // all ones -> q0=F q1=F

    initial begin
        checks   = 0;
        failures = 0;
        fa = 8'b0100_1110;
        fb = 8'b0101_0101;
        fc = 8'b1111_1111;
        rst = 1'b1;
        en  = 1'b0;
        sof = 1'b0;
        din = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        status("reset", 1'b0, 1'b0, 1'b0);
        words("reset", 4'h0, 4'h0);
        rst = 1'b0;

        // 1: continuous strobe, one frame
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), fa[k]);
            if (k < 7) status($sformatf("t1.b%0d", k), 1'b0, 1'b1, 1'b0);
        end
        status("t1.done", 1'b1, 1'b0, 1'b0);
        words("t1.done", 4'hA, 4'h3);
        step(1'b0, 1'b0, 1'b0);
        status("t1.after", 1'b0, 1'b0, 1'b0);

        // 2: strobe every other cycle
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), fa[k]);
            if (k < 7) begin
                status($sformatf("t2.b%0d", k), 1'b0, 1'b1, 1'b0);
                step(1'b0, 1'b0, ~fa[k]);
                status($sformatf("t2.gap%0d", k), 1'b0, 1'b1, 1'b0);
            end
        end
        status("t2.done", 1'b1, 1'b0, 1'b0);
        words("t2.done", 4'hA, 4'h3);
        step(1'b0, 1'b0, 1'b1);
        status("t2.hold", 1'b0, 1'b0, 1'b0);
        words("t2.hold", 4'hA, 4'h3);

        // 3: back-to-back frames, second sof in the valid cycle
        for (int k = 0; k < 8; k++) step(1'b1, (k == 0), fa[k]);
        status("t3.first", 1'b1, 1'b0, 1'b0);
        words("t3.first", 4'hA, 4'h3);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), fb[k]);
            if (k < 7) status($sformatf("t3.b%0d", k), 1'b0, 1'b1, 1'b0);
        end
        status("t3.second", 1'b1, 1'b0, 1'b0);
        words("t3.second", 4'hF, 4'h0);

        // 4: premature sof after 5 bits
        for (int k = 0; k < 5; k++) step(1'b1, (k == 0), 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), fc[k]);
            if (k == 0) begin
                status("t4.err", 1'b0, 1'b1, 1'b1);
                words("t4.err", 4'hF, 4'h0);
            end else if (k < 7) begin
                status($sformatf("t4.b%0d", k), 1'b0, 1'b1, 1'b0);
            end
        end
        status("t4.done", 1'b1, 1'b0, 1'b0);
        words("t4.done", 4'hF, 4'hF);

        // 7: sof on what would have been the final bit
        for (int k = 0; k < 7; k++) step(1'b1, (k == 0), 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, (k == 0), fb[k]);
            if (k == 0) begin
                status("t7.err", 1'b0, 1'b1, 1'b1);
                words("t7.err", 4'hF, 4'hF);
            end
        end
        status("t7.done", 1'b1, 1'b0, 1'b0);
        words("t7.done", 4'hF, 4'h0);

        // 5: asynchronous reset mid-frame
        for (int k = 0; k < 3; k++) step(1'b1, (k == 0), 1'b1);
        status("t5.pre", 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        status("t5.rst", 1'b0, 1'b0, 1'b0);
        words("t5.rst", 4'h0, 4'h0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, fa[k]);
            status($sformatf("t5.nosof%0d", k), 1'b0, 1'b0, 1'b0);
        end
        words("t5.nosof", 4'h0, 4'h0);
        for (int k = 0; k < 8; k++) step(1'b1, (k == 0), fa[k]);
        status("t5.done", 1'b1, 1'b0, 1'b0);
        words("t5.done", 4'hA, 4'h3);

        // 6: idle noise without sof
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 1'($urandom_range(1, 0)));
            status($sformatf("t6.c%0d", k), 1'b0, 1'b0, 1'b0);
        end
        words("t6.end", 4'hA, 4'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
